// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pcs_pkg
//  Purpose  : Shared definitions for preset_clear_seq: command opcodes,
//             sequencer state encoding and the cycle-counter reload helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pcs_pkg;

   // Command opcodes carried on cmd_op
   localparam logic [1:0] OP_NOP     = 2'b00;
   localparam logic [1:0] OP_CLEAR   = 2'b01;
   localparam logic [1:0] OP_PRESET  = 2'b10;
   localparam logic [1:0] OP_RELEASE = 2'b11;

   // Width of the per-state cycle counter
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BREAK = 2'd1,
      ST_HOLD  = 2'd2
   } pcs_state_e;

   // A state lasting n cycles is entered with n-1 loaded and leaves when
   // the counter reads zero.
   function automatic logic [CNT_W-1:0] cyc_reload(input int unsigned n);
      return CNT_W'(n - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pcs_popcount.sv
`default_nettype none
// ============================================================================
//  Module   : pcs_popcount
//  Purpose  : Combinational population count of a WIDTH-bit vector.
//  Ports    : bits_i  [WIDTH-1:0]           vector to count
//             count_o [$clog2(WIDTH+1)-1:0] number of ones in bits_i
//  Revision : 1.0  initial release
// ============================================================================
module pcs_popcount #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]             bits_i,
   output logic [$clog2(WIDTH+1)-1:0]   count_o
);

   localparam int CW = $clog2(WIDTH + 1);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count_o = count_o + CW'(bits_i[i]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/preset_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module   : preset_clear_seq
//  Purpose  : Sequences per-bit clear/preset controls for WIDTH downstream
//             flops, guaranteeing a break gap before a bit switches from one
//             control to the other and a minimum hold after raising one.
//  Ports    : clk        rising-edge clock
//             rst_n      asynchronous active-low reset (forces all clears on)
//             cmd_valid  command present
//             cmd_ready  command accepted when high with cmd_valid
//             cmd_op     00 NOP, 01 CLEAR, 10 PRESET, 11 RELEASE
//             cmd_mask   bits the command applies to
//             clear      per-bit active-high clear
//             preset     per-bit active-high preset
//             busy       sequence in progress (inverse of cmd_ready)
//             done       one-cycle completion pulse for non-NOP commands
//             forced_cnt popcount(clear|preset), only with the macro below
//  Options  : PRESET_CLEAR_SEQ_STATUS_EN adds the forced_cnt status output
//  Revision : 1.0  initial release
// ============================================================================
module preset_clear_seq
   import pcs_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned GAP_CYC  = 1,
   parameter int unsigned HOLD_CYC = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [WIDTH-1:0]             cmd_mask,
   output logic [WIDTH-1:0]             clear,
   output logic [WIDTH-1:0]             preset,
   output logic                         busy,
   output logic                         done
`ifdef PRESET_CLEAR_SEQ_STATUS_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0]   forced_cnt
`endif
);

   localparam logic [CNT_W-1:0] GAP_LD  = cyc_reload(GAP_CYC);
   localparam logic [CNT_W-1:0] HOLD_LD = cyc_reload(HOLD_CYC);

   pcs_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]    clear_q, clear_d;
   logic [WIDTH-1:0]    preset_q, preset_d;
   logic [WIDTH-1:0]    mask_q, mask_d;
   logic [1:0]          op_q, op_d;
   logic                ready_q, busy_q, done_q, done_d;
   logic                accept;

   assign accept = cmd_valid & ready_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clear_d  = clear_q;
      preset_d = preset_q;
      mask_d   = mask_q;
      op_d     = op_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // NOP and empty-mask commands are swallowed without effect
            if (accept && (cmd_op != OP_NOP) && (cmd_mask != '0)) begin
               mask_d = cmd_mask;
               op_d   = cmd_op;
               case (cmd_op)
                  OP_CLEAR: begin
                     preset_d = preset_q & ~cmd_mask;
                     // Only bits that really had the opposite control up
                     // need the break gap before the new control rises.
                     if ((preset_q & cmd_mask) != '0) begin
                        state_d = ST_BREAK;
                        cnt_d   = GAP_LD;
                     end else begin
                        clear_d = clear_q | cmd_mask;
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LD;
                     end
                  end
                  OP_PRESET: begin
                     clear_d = clear_q & ~cmd_mask;
                     if ((clear_q & cmd_mask) != '0) begin
                        state_d = ST_BREAK;
                        cnt_d   = GAP_LD;
                     end else begin
                        preset_d = preset_q | cmd_mask;
                        state_d  = ST_HOLD;
                        cnt_d    = HOLD_LD;
                     end
                  end
                  default: begin
                     // RELEASE always observes the gap so a following
                     // command cannot raise a control too early.
                     clear_d  = clear_q & ~cmd_mask;
                     preset_d = preset_q & ~cmd_mask;
                     state_d  = ST_BREAK;
                     cnt_d    = GAP_LD;
                  end
               endcase
            end
         end

         ST_BREAK: begin
            if (cnt_q == '0) begin
               if (op_q == OP_RELEASE) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  if (op_q == OP_CLEAR) begin
                     clear_d = clear_q | mask_q;
                  end else begin
                     preset_d = preset_q | mask_q;
                  end
                  state_d = ST_HOLD;
                  cnt_d   = HOLD_LD;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         clear_q  <= '1;
         preset_q <= '0;
         mask_q   <= '0;
         op_q     <= OP_NOP;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         clear_q  <= clear_d;
         preset_q <= preset_d;
         mask_q   <= mask_d;
         op_q     <= op_d;
         // Handshake flags are registered copies of the next state so they
         // stay aligned with state_q without a combinational output path.
         ready_q  <= (state_d == ST_IDLE);
         busy_q   <= (state_d != ST_IDLE);
         done_q   <= done_d;
      end
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign clear     = clear_q;
   assign preset    = preset_q;

`ifdef PRESET_CLEAR_SEQ_STATUS_EN
   localparam int FCW = $clog2(WIDTH + 1);

   logic [FCW-1:0] fcnt_d, fcnt_q;

   // Counting the next-state controls keeps forced_cnt aligned with the
   // registered clear/preset outputs.
   pcs_popcount #(
      .WIDTH (WIDTH)
   ) u_popcount (
      .bits_i  (clear_d | preset_d),
      .count_o (fcnt_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q <= FCW'(WIDTH);
      end else begin
         fcnt_q <= fcnt_d;
      end
   end

   assign forced_cnt = fcnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_preset_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_preset_clear_seq
//  Purpose  : Self-checking bench for preset_clear_seq (WIDTH=8, GAP_CYC=1,
//             HOLD_CYC=2). A command-level reference model expands every
//             accepted command into the expected per-cycle output frames.
//  Options  : PRESET_CLEAR_SEQ_STATUS_EN also checks forced_cnt
//  Revision : 1.0  initial release
// ============================================================================
module tb_preset_clear_seq;

   localparam int GAP  = 1;
   localparam int HOLD = 2;

   localparam logic [1:0] T_NOP = 2'b00, T_CLR = 2'b01, T_PRE = 2'b10, T_REL = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_mask = 8'h00;
   logic [7:0] clear, preset;
   logic       busy, done;
`ifdef PRESET_CLEAR_SEQ_STATUS_EN
   logic [3:0] forced_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   preset_clear_seq #(
      .WIDTH    (8),
      .GAP_CYC  (GAP),
      .HOLD_CYC (HOLD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_mask   (cmd_mask),
      .clear      (clear),
      .preset     (preset),
      .busy       (busy),
      .done       (done)
`ifdef PRESET_CLEAR_SEQ_STATUS_EN
      ,
      .forced_cnt (forced_cnt)
`endif
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0] clr;
      logic [7:0] pre;
      logic       rdy;
      logic       dn;
   } frame_t;

   frame_t     q[$];
   frame_t     cur;
   logic [7:0] lvl_clr, lvl_pre;

   function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endfunction

   function automatic void push_n(int n, logic [7:0] c, logic [7:0] p);
      for (int i = 0; i < n; i++) q.push_back('{clr: c, pre: p, rdy: 1'b0, dn: 1'b0});
   endfunction

   // Expand one accepted command into the frames seen after each later edge.
   function automatic void model_accept(logic [1:0] op, logic [7:0] m);
      logic [7:0] c1, p1;
      if (op == T_NOP || m == 8'h00) return;
      case (op)
         T_CLR: begin
            p1 = lvl_pre & ~m;
            c1 = lvl_clr | m;
            if ((lvl_pre & m) != 0) push_n(GAP, lvl_clr, p1);
            push_n(HOLD, c1, p1);
         end
         T_PRE: begin
            c1 = lvl_clr & ~m;
            p1 = lvl_pre | m;
            if ((lvl_clr & m) != 0) push_n(GAP, c1, lvl_pre);
            push_n(HOLD, c1, p1);
         end
         default: begin
            c1 = lvl_clr & ~m;
            p1 = lvl_pre & ~m;
            push_n(GAP, c1, p1);
         end
      endcase
      q.push_back('{clr: c1, pre: p1, rdy: 1'b1, dn: 1'b1});
      lvl_clr = c1;
      lvl_pre = p1;
   endfunction

   task automatic check_outputs(string ctx);
      chk({ctx, ":clear"},     32'(clear),     32'(cur.clr));
      chk({ctx, ":preset"},    32'(preset),    32'(cur.pre));
      chk({ctx, ":cmd_ready"}, 32'(cmd_ready), 32'(cur.rdy));
      chk({ctx, ":busy"},      32'(busy),      32'(!cur.rdy));
      chk({ctx, ":done"},      32'(done),      32'(cur.dn));
      chk({ctx, ":overlap"},   32'(clear & preset), 32'(0));
`ifdef PRESET_CLEAR_SEQ_STATUS_EN
      chk({ctx, ":forced_cnt"}, 32'(forced_cnt), 32'($countones(cur.clr | cur.pre)));
`endif
   endtask

   // One clock: model decides acceptance from its own ready, then outputs
   // are compared at the following falling edge.
   task automatic tick(string ctx, output bit acc);
      acc = cmd_valid && cur.rdy;
      if (acc) model_accept(cmd_op, cmd_mask);
      @(negedge clk);
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{clr: lvl_clr, pre: lvl_pre, rdy: 1'b1, dn: 1'b0};
      check_outputs(ctx);
   endtask

   task automatic drain(string ctx);
      bit a;
      int n = 0;
      while ((q.size() > 0 || !cur.rdy) && n < 64) begin
         tick(ctx, a);
         n++;
      end
      chk({ctx, ":drain_timeout"}, 32'(n < 64), 32'(1));
      tick(ctx, a);  // one idle cycle: done must be back low
   endtask

   task automatic issue(string ctx, logic [1:0] op, logic [7:0] m, bit do_drain);
      bit acc = 0;
      int n = 0;
      cmd_op    = op;
      cmd_mask  = m;
      cmd_valid = 1'b1;
      while (!acc && n < 64) begin
         tick(ctx, acc);
         n++;
      end
      cmd_valid = 1'b0;
      chk({ctx, ":accepted"}, 32'(acc), 32'(1));
      if (do_drain) drain(ctx);
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic pulse_reset(string ctx);
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      lvl_clr = 8'hFF;
      lvl_pre = 8'h00;
      cur = '{clr: 8'hFF, pre: 8'h00, rdy: 1'b1, dn: 1'b0};
      check_outputs({ctx, ":in_reset"});
      @(negedge clk);
      check_outputs({ctx, ":held_reset"});
      rst_n = 1'b1;
   endtask

   logic [1:0] b2b_op[7]   = '{T_PRE, T_CLR, T_REL, T_NOP, T_PRE, T_CLR, T_CLR};
   logic [7:0] b2b_mask[7] = '{8'hAA, 8'h0F, 8'h3C, 8'h11, 8'hFF, 8'h00, 8'h81};

   initial begin
      bit acc;
      int k;
      int n;

      lvl_clr = 8'hFF;
      lvl_pre = 8'h00;
      cur = '{clr: 8'hFF, pre: 8'h00, rdy: 1'b1, dn: 1'b0};
      @(negedge clk);
      pulse_reset("reset");

      // Release all, then preset low nibble, then clear across the preset
      issue("release_ff", T_REL, 8'hFF, 1'b1);
      issue("preset_0f",  T_PRE, 8'h0F, 1'b1);
      issue("clear_03",   T_CLR, 8'h03, 1'b1);
      // Clearing already-cleared bits still runs the full sequence
      issue("clear_03_again", T_CLR, 8'h03, 1'b1);
      // Commands that must be absorbed with no effect
      issue("nop",        T_NOP, 8'h5A, 1'b1);
      issue("clear_zero", T_CLR, 8'h00, 1'b1);

      // Reset during HOLD of a preset: abandoned with no done pulse
      issue("preset_f0", T_PRE, 8'hF0, 1'b0);
      tick("preset_f0_hold", acc);
      pulse_reset("mid_reset");
      drain("after_reset");

      // Back-to-back commands with cmd_valid held high
      k = 0;
      n = 0;
      cmd_valid = 1'b1;
      while (k < 7 && n < 200) begin
         cmd_op   = b2b_op[k];
         cmd_mask = b2b_mask[k];
         tick("b2b", acc);
         if (acc) k++;
         n++;
      end
      cmd_valid = 1'b0;
      chk("b2b:all_accepted", 32'(k), 32'(7));
      drain("b2b");

      // Randomized traffic with random valid gaps
      for (int i = 0; i < 600; i++) begin
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         tick("random", acc);
      end
      cmd_valid = 1'b0;
      drain("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/preset_clear_seq.md
PRESET_CLEAR_SEQ -- requirements
Module: preset_clear_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of downstream flops driven.
REQ-002 The block SHALL have parameter GAP_CYC, default 1 (range 1-15), giving the minimum cycles between dropping one control and raising the opposite control on the same bit.
REQ-003 The block SHALL have parameter HOLD_CYC, default 2 (range 1-15), giving the minimum cycles a newly raised control is held before the next command is accepted.
REQ-004 The block SHALL have these ports:
  clk        in   1      rising-edge clock
  rst_n      in   1      asynchronous, active-low reset
  cmd_valid  in   1      command present
  cmd_ready  out  1      command accepted this cycle when high together with cmd_valid
  cmd_op     in   2      00 NOP, 01 CLEAR, 10 PRESET, 11 RELEASE
  cmd_mask   in   WIDTH  bits the command applies to
  clear      out  WIDTH  per-bit active-high clear to downstream flops
  preset     out  WIDTH  per-bit active-high preset to downstream flops
  busy       out  1      sequence in progress; the inverse of cmd_ready
  done       out  1      one-cycle pulse marking completion of a non-NOP command

Function
REQ-005 All outputs SHALL be registered, and a command SHALL be accepted only on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-006 cmd_ready SHALL be 1 only in state IDLE; the states SHALL be IDLE, BREAK and HOLD.
REQ-007 NOP, and any command with cmd_mask=0, SHALL be accepted with no output change, no done pulse, and no state change.
REQ-008 CLEAR with mask m SHALL, at the accept edge, drop preset bits in m; if any such bit was 1, the block SHALL enter BREAK for GAP_CYC cycles and then set clear|=m on entry to HOLD; otherwise it SHALL set clear|=m at the accept edge and enter HOLD directly.
REQ-009 PRESET SHALL behave as REQ-008 with clear and preset swapped.
REQ-010 HOLD SHALL last exactly HOLD_CYC cycles, then return to IDLE with done=1 for the first IDLE cycle.
REQ-011 RELEASE with mask m SHALL, at the accept edge, drop clear and preset bits in m, enter BREAK for GAP_CYC cycles, then return to IDLE with done=1.
REQ-012 Bits outside the mask SHALL never change.
REQ-013 clear[i] and preset[i] SHALL never both be 1 in any cycle.
REQ-014 A control bit SHALL never rise fewer than GAP_CYC cycles after the opposite control on the same bit fell.
REQ-015 A CLEAR on bits already cleared SHALL still run a full HOLD and pulse done.
REQ-016 The cycle counter SHALL be 4 bits and SHALL reload on every state entry.

Reset
REQ-017 While rst_n=0, clear SHALL be all ones, preset all zeros, state IDLE, counter 0, and done 0, so that all downstream flops are held cleared.
REQ-018 When rst_n is asserted mid-sequence, the block SHALL abandon the sequence immediately without a done pulse.
REQ-019 After rst_n deasserts, cmd_ready SHALL be 1 on the first clock edge.

Configuration
REQ-020 With the macro PRESET_CLEAR_SEQ_STATUS_EN defined, the block SHALL add output forced_cnt, $clog2(WIDTH+1) bits, registered, equal to popcount(clear|preset), and reset to WIDTH.
REQ-021 Without PRESET_CLEAR_SEQ_STATUS_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-022 A shared package pcs_pkg SHALL hold the cmd_op encodings (OP_NOP, OP_CLEAR, OP_PRESET, OP_RELEASE) and the state enum.
REQ-023 One sub-module, pcs_popcount (combinational popcount of WIDTH bits), SHALL be instantiated only under PRESET_CLEAR_SEQ_STATUS_EN.

Verification (WIDTH=8, GAP_CYC=1, HOLD_CYC=2)
REQ-024 Reset release, then RELEASE with mask 0xFF -> clear 0xFF->0x00 at the accept edge, one BREAK cycle, then done=1 and cmd_ready=1.
REQ-025 PRESET with mask 0x0F from all-released -> preset=0x0F at the accept edge, cmd_ready low 2 cycles, done pulse, clear stays 0x00.
REQ-026 CLEAR with mask 0x03 while preset=0x0F -> preset=0x0C at the accept edge, clear=0x03 one cycle later, never both high on bits 0-1, done 3 cycles after accept.
REQ-027 cmd_valid held high with back-to-back commands -> each command accepted only when cmd_ready=1, and no command is lost or duplicated.
REQ-028 rst_n pulsed low during HOLD of PRESET 0xF0 -> clear=0xFF and preset=0x00 immediately, no done pulse, cmd_ready=1 after release.
REQ-029 NOP and CLEAR with mask 0x00 -> accepted in one cycle, no output change, done stays 0; with PRESET_CLEAR_SEQ_STATUS_EN, forced_cnt tracks popcount throughout.
